// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag lookup/refill controller for a SETS x 2-way tag SRAM.
// Define ICACHE_TAG_LRU_EN for per-set LRU replacement; otherwise a single round-robin bit is used.
module icache_tag_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic [ADDR_WIDTH-1:0]                          req_addr,
  output logic                                           resp_valid,
  output logic                                           resp_hit,
  output logic                                           resp_way,
  input  logic                                           flush,
  output logic                                           refill_req_valid,
  input  logic                                           refill_req_ready,
  output logic [ADDR_WIDTH-4:0]                          refill_req_addr,
  input  logic                                           refill_done,
  output logic                                           tag_csb,
  output logic                                           tag_web,
  output logic [1:0]                                     tag_wmask,
  output logic [$clog2(SETS)-1:0]                        tag_addr,
  output logic [2*(ADDR_WIDTH-$clog2(SETS)-3)+1:0]       tag_din,
  input  logic [2*(ADDR_WIDTH-$clog2(SETS)-3)+1:0]       tag_dout
);

  localparam int OFF_W  = 3;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int LINE_W = ADDR_WIDTH - OFF_W;
  localparam int ENT_W  = TAG_W + 1;

  typedef enum logic [2:0] {
    ST_FLUSH     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_COMPARE   = 3'd2,
    ST_MISS_REQ  = 3'd3,
    ST_MISS_WAIT = 3'd4,
    ST_TAG_WR    = 3'd5
  } state_e;

  function automatic logic entry_hit(input logic [ENT_W-1:0] ent, input logic [TAG_W-1:0] tag);
    return ent[ENT_W-1] && (ent[TAG_W-1:0] == tag);
  endfunction

  // Fill an invalid way first (way0 preferred); fall back to the policy only when both are valid.
  function automatic logic pick_victim(input logic v0, input logic v1, input logic pol);
    logic w;
    if (!v0) begin
      w = 1'b0;
    end else if (!v1) begin
      w = 1'b1;
    end else begin
      w = pol;
    end
    return w;
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              flush_pend_q, flush_pend_d;
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;
`ifdef ICACHE_TAG_LRU_EN
  logic [SETS-1:0]   lru_q, lru_d;
`else
  logic              rr_q, rr_d;
`endif

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [ENT_W-1:0]  ent0_s, ent1_s;
  logic              hit0_s, hit1_s, hit_way_s;
  logic              policy_s, victim_s, flush_any_s;
  logic              unused_addr_s;

  assign idx_s           = line_q[IDX_W-1:0];
  assign tag_s           = line_q[LINE_W-1:IDX_W];
  assign ent0_s          = tag_dout[ENT_W-1:0];
  assign ent1_s          = tag_dout[2*ENT_W-1:ENT_W];
  assign hit0_s          = entry_hit(ent0_s, tag_s);
  assign hit1_s          = entry_hit(ent1_s, tag_s);
  assign hit_way_s       = ~hit0_s & hit1_s;
  assign flush_any_s     = flush_pend_q | flush;
  assign refill_req_addr = line_q;
  assign unused_addr_s   = ^req_addr[OFF_W-1:0];
`ifdef ICACHE_TAG_LRU_EN
  assign policy_s = lru_q[idx_s];
`else
  assign policy_s = rr_q;
`endif
  assign victim_s = pick_victim(v0_q, v1_q, policy_s);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q | flush;
    v0_d         = v0_q;
    v1_d         = v1_q;
`ifdef ICACHE_TAG_LRU_EN
    lru_d        = lru_q;
`else
    rr_d         = rr_q;
`endif
    case (state_q)
      ST_FLUSH: begin
        cnt_d = cnt_q + IDX_W'(1);
`ifdef ICACHE_TAG_LRU_EN
        lru_d = '0;
`else
        rr_d  = 1'b0;
`endif
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_IDLE: begin
        if (flush_any_s) begin
          state_d      = ST_FLUSH;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (req_valid) begin
          line_d  = req_addr[ADDR_WIDTH-1:OFF_W];
          state_d = ST_COMPARE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        // Valid bits are kept for victim choice after the refill.
        v0_d = ent0_s[ENT_W-1];
        v1_d = ent1_s[ENT_W-1];
        if (hit0_s || hit1_s) begin
          state_d = ST_IDLE;
`ifdef ICACHE_TAG_LRU_EN
          lru_d[idx_s] = ~hit_way_s;
`endif
        end else begin
          state_d = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (refill_req_ready) begin
          state_d = ST_MISS_WAIT;
        end else begin
          state_d = ST_MISS_REQ;
        end
      end
      ST_MISS_WAIT: begin
        if (refill_done) begin
          state_d = ST_TAG_WR;
        end else begin
          state_d = ST_MISS_WAIT;
        end
      end
      ST_TAG_WR: begin
        state_d = ST_IDLE;
`ifdef ICACHE_TAG_LRU_EN
        lru_d[idx_s] = ~victim_s;
`else
        if (v0_q && v1_q) begin
          rr_d = ~rr_q;
        end else begin
          rr_d = rr_q;
        end
`endif
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_hit         = 1'b0;
    resp_way         = 1'b0;
    refill_req_valid = 1'b0;
    tag_csb          = 1'b1;
    tag_web          = 1'b1;
    tag_wmask        = 2'b00;
    tag_addr         = '0;
    tag_din          = '0;
    if (!rst) begin
      case (state_q)
        ST_FLUSH: begin
          tag_csb   = 1'b0;
          tag_web   = 1'b0;
          tag_wmask = 2'b11;
          tag_addr  = cnt_q;
        end
        ST_IDLE: begin
          req_ready = ~flush_any_s;
          if (!flush_any_s && req_valid) begin
            tag_csb  = 1'b0;
            tag_addr = req_addr[OFF_W+IDX_W-1:OFF_W];
          end else begin
            tag_csb  = 1'b1;
          end
        end
        ST_COMPARE: begin
          resp_valid = 1'b1;
          resp_hit   = hit0_s | hit1_s;
          resp_way   = hit_way_s;
        end
        ST_MISS_REQ: begin
          refill_req_valid = 1'b1;
        end
        ST_TAG_WR: begin
          tag_csb   = 1'b0;
          tag_web   = 1'b0;
          tag_wmask = victim_s ? 2'b10 : 2'b01;
          tag_addr  = idx_s;
          tag_din   = {1'b1, tag_s, 1'b1, tag_s};
        end
        default: begin
          tag_csb = 1'b1;
        end
      endcase
    end else begin
      req_ready        = 1'b0;
      refill_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FLUSH;
      cnt_q        <= '0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
`ifdef ICACHE_TAG_LRU_EN
      lru_q        <= '0;
`else
      rr_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
`ifdef ICACHE_TAG_LRU_EN
      lru_q        <= lru_d;
`else
      rr_q         <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Randomized self-checking bench for icache_tag_ctrl with a set/way reference model and a tag SRAM.
module tb_icache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        resp_valid, resp_hit, resp_way;
  logic        flush = 1'b0;
  logic        refill_req_valid;
  logic        refill_req_ready = 1'b0;
  logic [28:0] refill_req_addr;
  logic        refill_done = 1'b0;
  logic        tag_csb, tag_web;
  logic [1:0]  tag_wmask;
  logic [5:0]  tag_addr;
  logic [47:0] tag_din;
  logic [47:0] tag_dout;

  always #5 clk = ~clk;

  icache_tag_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .flush(flush),
    .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
    .refill_req_addr(refill_req_addr), .refill_done(refill_done),
    .tag_csb(tag_csb), .tag_web(tag_web), .tag_wmask(tag_wmask),
    .tag_addr(tag_addr), .tag_din(tag_din), .tag_dout(tag_dout)
  );

  // Tag SRAM: masked write, registered read.
  logic [47:0] sram [64];
  always @(posedge clk) begin
    if (!tag_csb) begin
      if (!tag_web) begin
        if (tag_wmask[0]) sram[tag_addr][23:0]  <= tag_din[23:0];
        if (tag_wmask[1]) sram[tag_addr][47:24] <= tag_din[47:24];
      end else begin
        tag_dout <= sram[tag_addr];
      end
    end
  end

  // Reference model: per set/way valid + tag, replacement state.
  bit          mv   [2][64];
  logic [22:0] mt   [2][64];
  bit          mlru [64];
  bit          mrr;

  int          n_checks = 0;
  int          n_bad    = 0;
  bit          last_hit;
  logic [1:0]  last_wmask;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      mv[0][i] = 1'b0;
      mv[1][i] = 1'b0;
      mlru[i]  = 1'b0;
    end
    mrr = 1'b0;
  endtask

  // Entered at a negedge whose cycle is FLUSH with cnt=0.
  task automatic check_walk();
    logic [5:0] ia;
    for (int i = 0; i < 64; i++) begin
      ia = 6'(i);
      #1;
      check_val("walk", 64'({tag_csb, tag_web, tag_wmask, tag_addr, req_ready, tag_din}),
                64'({1'b0, 1'b0, 2'b11, ia, 1'b0, 48'h0}));
      @(negedge clk);
    end
    #1;
    check_val("walk_done_ready", 64'(req_ready), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; refill_req_ready = 1'b0; refill_done = 1'b0;
    #1;
    check_val("rst_outs", 64'({req_ready, resp_valid, refill_req_valid, tag_csb, tag_web, tag_wmask}),
              64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00}));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_walk();
  endtask

  task automatic idle_flush();
    #1;
    flush = 1'b1;
    #1;
    check_val("flush_blocks_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    check_walk();
  endtask

  // mode 0: normal, 1: flush pulse in MISS_WAIT, 2: rst while in MISS_REQ
  task automatic do_lookup(input logic [31:0] a, input int mode);
    int          n;
    bit          eh, ew, vic;
    logic [5:0]  idx;
    logic [22:0] tg;
    logic [1:0]  wexp;
    idx = a[8:3];
    tg  = a[31:9];
    n = 0;
    #1;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("req_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    check_val("rd_port", 64'({tag_csb, tag_web, tag_addr}), 64'({1'b0, 1'b1, idx}));
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    #1;
    eh = 1'b0;
    ew = 1'b0;
    if (mv[0][idx] && mt[0][idx] == tg) begin
      eh = 1'b1;
    end else if (mv[1][idx] && mt[1][idx] == tg) begin
      eh = 1'b1;
      ew = 1'b1;
    end
    check_val("resp", 64'({resp_valid, resp_hit, resp_way}), 64'({1'b1, eh, ew}));
    last_hit = resp_hit;
    if (eh) begin
      mlru[idx] = ~ew;
      @(negedge clk);
      #1;
      check_val("hit_ready", 64'(req_ready), 64'(1));
      return;
    end
    if (!mv[0][idx])      vic = 1'b0;
    else if (!mv[1][idx]) vic = 1'b1;
    else begin
`ifdef ICACHE_TAG_LRU_EN
      vic = mlru[idx];
`else
      vic = mrr;
`endif
    end
    @(negedge clk);
    #1;
    check_val("refill_req", 64'({refill_req_valid, refill_req_addr}), 64'({1'b1, a[31:3]}));
    if (mode == 2) begin
      rst = 1'b1;
      #1;
      check_val("rst_drops_refill", 64'({refill_req_valid, tag_csb}), 64'({1'b0, 1'b1}));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      check_walk();
      return;
    end
    n = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      refill_done = (k == 0);
      @(negedge clk);
      refill_done = 1'b0;
      #1;
      check_val("refill_hold", 64'({refill_req_valid, refill_req_addr}), 64'({1'b1, a[31:3]}));
    end
    refill_req_ready = 1'b1;
    @(negedge clk);
    refill_req_ready = 1'b0;
    #1;
    check_val("miss_wait", 64'({refill_req_valid, tag_csb}), 64'({1'b0, 1'b1}));
    flush = (mode == 1);
    @(negedge clk);
    flush = 1'b0;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) @(negedge clk);
    #1;
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    #1;
    wexp = vic ? 2'b10 : 2'b01;
    check_val("tag_wr", 64'({tag_csb, tag_web, tag_wmask, tag_addr}), 64'({1'b0, 1'b0, wexp, idx}));
    check_val("tag_din", 64'(tag_din), 64'({1'b1, tg, 1'b1, tg}));
    last_wmask = tag_wmask;
    mlru[idx] = ~vic;
    if (mv[0][idx] && mv[1][idx]) mrr = ~mrr;
    mv[vic][idx] = 1'b1;
    mt[vic][idx] = tg;
    @(negedge clk);
    #1;
    if (mode == 1) begin
      check_val("flush_pending_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      model_clear();
      check_walk();
    end else begin
      check_val("fill_ready", 64'(req_ready), 64'(1));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [5:0]  ri;
    logic [22:0] rt;
    logic [1:0]  repl_exp;
    int          r, mode;

`ifdef ICACHE_TAG_LRU_EN
    repl_exp = 2'b10;
`else
    repl_exp = 2'b01;
`endif
    do_reset();

    do_lookup(32'h0000_1008, 0);
    check_val("cold_miss", 64'(last_hit), 64'(0));
    check_val("cold_wmask", 64'(last_wmask), 64'(2'b01));
    do_lookup(32'h0000_1008, 0);
    check_val("rehit_way0", 64'(last_hit), 64'(1));
    do_lookup(32'h0000_2008, 0);
    check_val("second_wmask", 64'(last_wmask), 64'(2'b10));
    do_lookup(32'h0000_2008, 0);
    do_lookup(32'h0000_1008, 0);
    do_lookup(32'h0000_3008, 0);
    check_val("repl_victim", 64'(last_wmask), 64'(repl_exp));
    do_lookup(32'h0000_4010, 1);
    do_lookup(32'h0000_1008, 0);
    check_val("post_flush_miss", 64'(last_hit), 64'(0));
    do_lookup(32'h0000_5008, 2);

    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0:       ri = 6'd0;
        1:       ri = 6'd1;
        2:       ri = 6'd2;
        default: ri = 6'd63;
      endcase
      case ($urandom_range(0, 3))
        0:       rt = 23'h8;
        1:       rt = 23'h10;
        2:       rt = 23'h18;
        default: rt = 23'($urandom);
      endcase
      a = {rt, ri, 3'($urandom)};
      if (r < 3) idle_flush();
      mode = (r >= 3 && r < 8) ? 1 : ((r == 8) ? 2 : 0);
      do_lookup(a, mode);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_tag_ctrl.md
# icache_tag_ctrl

Lookup/refill controller for the instruction-cache tag array: accepts fetch-address lookups, drives the 64-set × 2-way tag SRAM (48-bit word: way1 {valid, tag[22:0]} in [47:24], way0 in [23:0]), compares the returned tags, and reports hit/miss plus hit way. On a miss it requests a line refill from the memory side, chooses a victim way and writes the new tag. It sits directly upstream of the tag SRAM and downstream of the fetch unit.

## Interface
- ADDR_WIDTH, 32, fetch address width; offset [2:0], index [8:3], tag [31:9]
- SETS, 64, number of sets; the index is log2(SETS) = 6 bits
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid / req_ready  in/out  1  lookup handshake
- req_addr  in  32  fetch address
- resp_valid  out  1  one-cycle lookup result strobe; there is no backpressure
- resp_hit / resp_way  out  1/1  hit flag; hit way (0 on a miss)
- flush  in  1  single-cycle pulse: invalidate all sets
- refill_req_valid / refill_req_ready  out/in  1  miss handshake to memory
- refill_req_addr  out  29  line address, req_addr[31:3]
- refill_done  in  1  pulse: line data has been written to the data array
- tag_csb / tag_web  out  1/1  SRAM chip select / write enable, both active-low
- tag_wmask  out  2  bit0 = way0 half, bit1 = way1 half
- tag_addr  out  6  set index
- tag_din  out  48  write data
- tag_dout  in  48  read data, valid in the cycle after the address is sampled

## Operation
- States: FLUSH, IDLE, COMPARE, MISS_REQ, MISS_WAIT, TAG_WR.
- **FLUSH**
  - 6-bit counter cnt steps 0..63.
  - Each cycle drives tag_csb=0, tag_web=0, tag_wmask=11, tag_addr=cnt, tag_din=0.
  - Clears the replacement state.
  - At cnt=63, goes to IDLE. req_ready=0 throughout.
- **IDLE**
  - req_ready=1.
  - On req_valid:
    - Latches req_addr.
    - Drives tag_csb=0, tag_web=1, tag_addr=req_addr[8:3] in the same cycle.
    - Goes to COMPARE.
  - A pending flush has priority over req_valid: req_ready=0 and go to FLUSH.
- **COMPARE**
  - resp_valid=1. resp_* are combinational from tag_dout.
  - hitN = valid bit of way N && tag of way N == latched tag.
  - If both ways hit, report way0.
  - Hit: update replacement state, go to IDLE.
  - Miss: go to MISS_REQ.
- **MISS_REQ**
  - refill_req_valid=1, with refill_req_addr held stable.
  - Leaves for MISS_WAIT on refill_req_ready.
  - refill_done is ignored in this state.
- **MISS_WAIT**
  - Waits for refill_done, then goes to TAG_WR.
- **TAG_WR**
  - Drives tag_csb=0, tag_web=0, tag_wmask = one-hot victim, tag_din = {1, tag, 1, tag}.
  - Updates replacement state. Goes to IDLE.
- **Victim selection**
  - Way0 if it is invalid, else way1 if it is invalid, else the replacement policy (see Configuration).
  - Valid bits come from tag_dout captured in COMPARE.
- **flush pulse**
  - Arriving outside IDLE: latched as pending and served on the next entry to IDLE.
  - An in-progress miss always completes first.
- **Default outputs** when not driven by the current state: tag_csb=1, tag_web=1, tag_wmask=00, tag_addr=0, tag_din=0.

## Timing
- **rst**
  - Next state is FLUSH with cnt=0; the pending flush is cleared.
  - All outputs take their default values while rst is high, including resp_valid=0, refill_req_valid=0 and req_ready=0.
  - rst mid-miss abandons the refill: refill_req_valid drops in the cycle rst is sampled.
- **After reset**: the first request can be accepted 64 cycles after rst is released.
- **Lookup latency**
  - Accept at edge E0; resp_valid is high for exactly the cycle between E0 and E1.
  - On a hit, req_ready is high again from E1, so throughput is 1 lookup per 2 cycles.
- **Miss**
  - resp_valid with resp_hit=0 in COMPARE.
  - refill_req_valid rises the following cycle.
  - The tag write takes 1 cycle after the cycle refill_done is sampled.
  - req_ready returns to 1 the cycle after TAG_WR.
  - Upstream re-issues the request, which then hits.

## Configuration
- **ICACHE_TAG_LRU_EN defined**
  - A 64-entry 1-bit LRU array; each entry holds the way to evict next.
  - On a hit or a fill to way w: lru[idx] = ~w.
  - Cleared to 0 during FLUSH.
- **ICACHE_TAG_LRU_EN undefined**
  - A single round-robin bit, reset to 0 by FLUSH.
  - Used as the victim only when both ways are valid, and toggled after each such fill.
  - Hits do not change it.

## Test plan
- **Reset walk**: assert rst 2 cycles then release → 64 SRAM writes, addr 0..63, wmask 11, din 0, each 1 cycle; req_ready=0 during the walk, then 1.
- **Cold miss, req_addr 0x00001008** (idx 1, tag 0x8):
  - resp_valid, resp_hit=0.
  - refill_req_addr=0x0000201 until ready.
  - After refill_done: write addr 1, wmask 01, din[23:0]=0x800008.
  - Re-request gives resp_hit=1, resp_way=0.
- **Second line same set, 0x00002008** (tag 0x10): miss, filled into way1 (wmask 10, din[47:24]=0x800010); re-request hits way1.
- **Replacement**: after the above, hit 0x1008, then miss on 0x00003008.
  - With ICACHE_TAG_LRU_EN: victim is way1, wmask 10.
  - Without it: victim is way0, wmask 01.
- **Flush during MISS_WAIT**: pulse flush, then refill_done → TAG_WR completes first, then the 64-cycle walk; 0x1008 then misses.
- **rst during MISS_REQ** with refill_req_ready held 0 → refill_req_valid=0 in the cycle rst is sampled; the walk restarts at cnt=0.
